// File: rtl/calcu16_mem_arbiter.sv
// calcu16 memory arbiter: shares the single-port memory between IF and LS.
// Optional build macro CALCU16_MEMARB_RR_EN selects round-robin arbitration.
`timescale 1ns/1ps
module calcu16_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 26,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_lat_cnt;

    logic w_idle;
    logic w_issue;
    logic w_done;
    logic w_pick_if;
    logic w_pick_ls;
    logic w_own_if;
    logic w_own_ls;

    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = (r_state == S_ISSUE);
    assign w_done   = (r_state == S_WAIT) && (r_lat_cnt == 3'd1);
    assign w_own_if = (r_owner == OWN_IF);
    assign w_own_ls = (r_owner == OWN_LS);

`ifdef CALCU16_MEMARB_RR_EN
    logic r_last_ls;

    // Contention goes to whichever side did not win the previous grant.
    always_comb begin
        w_pick_ls = ls_req && (!if_req || !r_last_ls);
        w_pick_if = if_req && !w_pick_ls;
    end

    // Remember the most recent winner; starts as IF so LS wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_ls <= 1'b0;
        end else if (w_idle && w_pick_ls) begin
            r_last_ls <= 1'b1;
        end else if (w_idle && w_pick_if) begin
            r_last_ls <= 1'b0;
        end
    end
`else
    logic [3:0] r_starve;
    logic       w_force_if;

    assign w_force_if = if_req && (r_starve == 4'(STARVE_MAX));

    // LS has priority unless IF has been passed over too many times.
    always_comb begin
        w_pick_ls = ls_req && !w_force_if;
        w_pick_if = if_req && !w_pick_ls;
    end

    // Count LS wins over a waiting IF; saturate, clear when IF is served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (w_idle) begin
            if (!if_req) begin
                r_starve <= 4'd0;
            end else if (w_pick_if) begin
                r_starve <= 4'd0;
            end else if (w_pick_ls &&
                         (r_starve != 4'(STARVE_MAX))) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`endif

    // Request sequencer: latch the winner, issue once, wait for read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_NONE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_ls) begin
                        r_state <= S_ISSUE;
                        r_owner <= OWN_LS;
                        r_we    <= ls_we;
                        r_addr  <= ls_addr;
                        r_wdata <= ls_wdata;
                    end else if (w_pick_if) begin
                        r_state <= S_ISSUE;
                        r_owner <= OWN_IF;
                        r_we    <= 1'b0;
                        r_addr  <= if_addr;
                        r_wdata <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                        r_owner <= OWN_NONE;
                        r_we    <= 1'b0;
                    end else begin
                        r_state   <= S_WAIT;
                        r_lat_cnt <= 3'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == 3'd1) begin
                        r_state   <= S_IDLE;
                        r_owner   <= OWN_NONE;
                        r_lat_cnt <= 3'd0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Memory side is driven only during the single issue cycle.
    always_comb begin
        mem_en    = w_issue;
        mem_we    = w_issue && r_we;
        mem_addr  = w_issue ? r_addr : '0;
        mem_wdata = w_issue ? r_wdata : '0;
    end

    // Grant and read-return pulses go to the latched owner only.
    always_comb begin
        if_gnt    = w_issue && w_own_if;
        ls_gnt    = w_issue && w_own_ls;
        if_rvalid = w_done && w_own_if;
        ls_rvalid = w_done && w_own_ls;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_calcu16_mem_arbiter.sv
// Testbench for calcu16_mem_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-schedule model.
`timescale 1ns/1ps
module tb_calcu16_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 26;
    localparam int RL = 3;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    calcu16_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[9:0], a} ^ 26'h15A5A5A;
    endfunction

    // ---------------- memory device (drives mem_rdata) ----------------
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    bit            cap_v;
    bit   [DW-1:0] cap_d;
    bit            pv [RL];
    bit   [DW-1:0] pd [RL];
    bit   [DW-1:0] junk;

    always @(negedge clk) begin
        cap_v = mem_en && !mem_we;
        cap_d = mem_arr.exists(mem_addr) ? mem_arr[mem_addr]
                                         : dflt(mem_addr);
        if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    end

    always @(posedge clk) begin
        pv[0] <= cap_v;
        pd[0] <= cap_d;
        for (int i = 1; i < RL; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        junk <= DW'($urandom);
    end

    assign mem_rdata = pv[RL-1] ? pd[RL-1] : junk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          ig;
        logic          ir;
        logic [DW-1:0] ird;
        logic          lg;
        logic          lr;
        logic [DW-1:0] lrd;
        logic          en;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t          exp_q [int];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            free_cyc = 0;
    int            starve = 0;
    bit            last_ls = 1'b0;

    // observations for directed checks
    int            if_gnt_cyc, if_rv_cyc, ls_gnt_cyc, ls_rv_cyc;
    logic [DW-1:0] if_rd_last, ls_rd_last;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    int            n_mem_en = 0;
    int            n_ls_gnt = 0;
    int            n_ls_rv = 0;
    bit            seen_if_gnt = 0;
    bit            seen_ls_gnt = 0;
    bit            rec_on = 0;
    int            seq_q [$];

    always @(negedge clk) begin
        exp_t e, a, g, rv;
        bit wi, wl;
        logic [DW-1:0] rd;
        a = '{ig: if_gnt, ir: if_rvalid, ird: if_rdata,
              lg: ls_gnt, lr: ls_rvalid, lrd: ls_rdata,
              en: mem_en, we: mem_we, a: mem_addr, wd: mem_wdata};
        e = '0;
        if (!rst_n) begin
            exp_q.delete();
            free_cyc = cyc + 1;
            starve = 0;
            last_ls = 1'b0;
        end else begin
            if (exp_q.exists(cyc)) begin
                e = exp_q[cyc];
                exp_q.delete(cyc);
            end
            if (cyc >= free_cyc) begin
                wi = 0;
                wl = 0;
                if (if_req && ls_req) begin
`ifdef CALCU16_MEMARB_RR_EN
                    if (last_ls) wi = 1; else wl = 1;
`else
                    if (starve >= SM) wi = 1; else wl = 1;
`endif
                end else if (if_req) begin
                    wi = 1;
                end else if (ls_req) begin
                    wl = 1;
                end
`ifdef CALCU16_MEMARB_RR_EN
                if (wi) last_ls = 0;
                if (wl) last_ls = 1;
`else
                if (!if_req) starve = 0;
                else if (wi) starve = 0;
                else if (wl) starve = (starve < SM) ? starve + 1 : SM;
`endif
                if (wi || wl) begin
                    g = '0;
                    g.en = 1;
                    g.ig = wi;
                    g.lg = wl;
                    g.we = wl && ls_we;
                    g.a  = wl ? ls_addr : if_addr;
                    g.wd = wl ? ls_wdata : '0;
                    exp_q[cyc+1] = g;
                    if (g.we) begin
                        ref_mem[g.a] = ls_wdata;
                        free_cyc = cyc + 2;
                    end else begin
                        rd = ref_mem.exists(g.a) ? ref_mem[g.a] : dflt(g.a);
                        rv = '0;
                        rv.ir = wi;
                        rv.lr = wl;
                        if (wi) rv.ird = rd; else rv.lrd = rd;
                        exp_q[cyc+1+RL] = rv;
                        free_cyc = cyc + 2 + RL;
                    end
                end
            end
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d outputs: got ig=%b ir=%b ird=%h lg=%b lr=%b lrd=%h en=%b we=%b a=%h wd=%h expected ig=%b ir=%b ird=%h lg=%b lr=%b lrd=%h en=%b we=%b a=%h wd=%h",
                     cyc, a.ig, a.ir, a.ird, a.lg, a.lr, a.lrd, a.en,
                     a.we, a.a, a.wd, e.ig, e.ir, e.ird, e.lg, e.lr,
                     e.lrd, e.en, e.we, e.a, e.wd);
        end
        seen_if_gnt = if_gnt;
        seen_ls_gnt = ls_gnt;
        if (mem_en) n_mem_en++;
        if (if_gnt) if_gnt_cyc = cyc;
        if (ls_gnt) begin
            ls_gnt_cyc = cyc;
            n_ls_gnt++;
            g_we = mem_we;
            g_addr = mem_addr;
            g_wdata = mem_wdata;
        end
        if (if_rvalid) begin
            if_rv_cyc = cyc;
            if_rd_last = if_rdata;
        end
        if (ls_rvalid) begin
            ls_rv_cyc = cyc;
            ls_rd_last = ls_rdata;
            n_ls_rv++;
        end
        if (rec_on && if_gnt) seq_q.push_back(0);
        if (rec_on && ls_gnt) seq_q.push_back(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic do_req(input bit ls, input bit we,
                          input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd);
        int n;
        n = 0;
        if (ls) begin
            ls_req = 1; ls_we = we; ls_addr = ad; ls_wdata = wd;
        end else begin
            if_req = 1; if_addr = ad;
        end
        tick();
        while (!(ls ? seen_ls_gnt : seen_if_gnt) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant expected grant");
        end
        if (ls) ls_req = 0; else if_req = 0;
    endtask

    function automatic logic [AW-1:0] raddr;
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h1234;
            3: return 16'h0010;
            default: return {12'h0, 4'($urandom)};
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n0, nrv, ngnt, nen, n;
        int want_seq [10];
        mem_arr[16'h0010] = 26'h2A5A5A5;
        ref_mem[16'h0010] = 26'h2A5A5A5;

        // reset and idle
        idle(3);
        rst_n = 1'b1;
        idle(10);
        chk("idle_no_mem_en", 32'(n_mem_en), 32'd0);

        // single fetch
        n0 = cyc;
        do_req(0, 0, 16'h0010, '0);
        idle(RL + 2);
        chk("fetch_gnt_lat", 32'(if_gnt_cyc - n0), 32'd1);
        chk("fetch_rv_lat", 32'(if_rv_cyc - n0), 32'(1 + RL));
        chk("fetch_data", 32'(if_rd_last), 32'h2A5A5A5);

        // store then load of the same word
        do_req(1, 1, 16'h1234, 26'h0000ABC);
        chk("store_we", 32'(g_we), 32'd1);
        chk("store_addr", 32'(g_addr), 32'h1234);
        chk("store_wdata", 32'(g_wdata), 32'hABC);
        do_req(1, 0, 16'h1234, '0);
        idle(RL + 2);
        chk("load_rv_lat", 32'(ls_rv_cyc - ls_gnt_cyc), 32'(RL));
        chk("load_data", 32'(ls_rd_last), 32'h0000ABC);

        // contention with both requesters held high
        do_reset();
`ifdef CALCU16_MEMARB_RR_EN
        want_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        want_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
        seq_q.delete();
        rec_on = 1;
        if_req = 1; if_addr = 16'h0100;
        ls_req = 1; ls_we = 0; ls_addr = 16'h0200;
        n = 0;
        while (seq_q.size() < 10 && n < 200) begin
            tick();
            n++;
            if (seen_if_gnt) if_addr = if_addr + 16'd1;
            if (seen_ls_gnt) ls_addr = ls_addr + 16'd1;
        end
        rec_on = 0;
        if_req = 0;
        ls_req = 0;
        idle(RL + 3);
        chk("contention_count", 32'(seq_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < seq_q.size(); i++)
            chk($sformatf("contention_grant_%0d", i),
                32'(seq_q[i]), 32'(want_seq[i]));

        // reset while a load is in flight
        nrv = n_ls_rv;
        do_req(1, 0, 16'h0042, '0);
        tick();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(8);
        chk("no_rvalid_after_reset", 32'(n_ls_rv), 32'(nrv));
        do_req(0, 0, 16'h0020, '0);
        idle(RL + 2);
        chk("post_reset_fetch_lat", 32'(if_rv_cyc - if_gnt_cyc), 32'(RL));
        chk("post_reset_fetch_data", 32'(if_rd_last), 32'(dflt(16'h0020)));

        // LS pulse while busy is withdrawn, never served
        do_req(0, 0, 16'h0030, '0);
        ngnt = n_ls_gnt;
        nen = n_mem_en;
        ls_req = 1; ls_we = 1; ls_addr = 16'h7777; ls_wdata = 26'h1111111;
        tick();
        ls_req = 0;
        idle(RL + 4);
        chk("withdrawn_no_gnt", 32'(n_ls_gnt), 32'(ngnt));
        chk("withdrawn_no_mem", 32'(n_mem_en), 32'(nen));

        // random traffic
        for (int i = 0; i < 800; i++) begin
            tick();
            if (if_req && seen_if_gnt) begin
                if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = raddr();
            end
            if (ls_req && seen_ls_gnt) begin
                ls_req = 0;
            end else if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1;
                ls_we = 1'($urandom);
                ls_addr = raddr();
                ls_wdata = DW'($urandom);
            end
        end
        if_req = 0;
        ls_req = 0;
        idle(RL + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calcu16_mem_arbiter.md
Name: calcu16_mem_arbiter

Overview:
Shares the single-port 26-bit CPU memory between two requesters: the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write). It sits between the fetch/execute sequencer and the memory array and replaces the direct same-cycle memory access with a registered request/grant protocol. Only one access is outstanding at a time. LS has priority, and a starvation guard bounds how long IF can wait.

Parameters:
ADDR_W, 16, memory address width (word address)
DATA_W, 26, memory word width (instruction/data word)
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal 1..4
STARVE_MAX, 4, max consecutive LS grants while IF is pending before IF is forced; legal 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: IF access issued this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word; 0 when if_rvalid low
ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  one-cycle pulse: LS access issued this cycle
ls_rvalid  out  1  one-cycle pulse: ls_rdata valid (loads only)
ls_rdata  out  DATA_W  loaded word; 0 when ls_rvalid low
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: every output is 0, state = IDLE, owner = none, latency counter = 0, starvation counter = 0.
- States:
  - IDLE: sample requests; on a winner, latch owner, we, addr and wdata into registers and go to ISSUE; with no request, stay in IDLE.
  - ISSUE (exactly one cycle): mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values; the owner's gnt=1. A store goes to IDLE. A load goes to WAIT with counter=RD_LAT.
  - WAIT: counter decrements each cycle. In the cycle where counter==1, mem_rdata is valid: the owner's rvalid=1 and its rdata = mem_rdata; then go to IDLE.
- Timing:
  - Load: request seen in IDLE at cycle N → gnt at N+1 → rvalid at N+1+RD_LAT.
  - Store: gnt at N+1, no rvalid.
  - Minimum spacing between accepted requests: 2 cycles for a store, 2+RD_LAT cycles for a load.
- Requests are ignored outside IDLE. A requester deasserting req before gnt withdraws the request legally; nothing is issued for it.
- Arbitration (default build):
  - LS wins over IF when both are pending in IDLE.
  - Starvation counter: increments on each LS grant made while if_req=1; cleared on any IF grant or whenever if_req=0 in IDLE; saturates at STARVE_MAX.
  - When the counter == STARVE_MAX and if_req=1, IF wins.
- Address/data pass through unmodified; no address arithmetic. Full ADDR_W range is legal; 0xFFFF is not special.
- Reset mid-operation: an in-flight read is discarded (no rvalid after reset). Counters are cleared. Behaviour after reset release is the same as from cold.
- Simultaneous events: when rvalid is asserted in the last WAIT cycle, no new grant occurs in that same cycle; new requests are sampled in the next cycle (IDLE).
- Exactly one of if_gnt/ls_gnt can be 1 in a cycle, and only in ISSUE. The gnt and rvalid pulses are each exactly one cycle.

Optional Feature:
- Macro: CALCU16_MEMARB_RR_EN.
- Defined: fixed priority and the starvation counter are removed. When both requesters are pending, the requester not granted last wins (strict alternation). A last-winner flag resets to IF, so LS wins the first contention after reset. Single requests are granted normally. STARVE_MAX is unused.
- Undefined: fixed LS priority with the starvation guard, as above.

Test Plan:
- Reset/idle: rst_n=0 then 1 with no requests → all outputs 0 for 10 cycles; mem_en never asserted.
- Single fetch, RD_LAT=1: if_req, if_addr=0x0010, mem returns 26'h2A5A5A5 → if_gnt at N+1, if_rvalid/if_rdata=26'h2A5A5A5 at N+2, request count 1.
- Store then load, RD_LAT=3: ls_we=1, addr=0x1234, wdata=26'h0000ABC; then load of 0x1234 → mem_we=1 with that address/data at the grant cycle; load rvalid 3 cycles after its gnt with data 26'h0000ABC.
- Contention, default build, STARVE_MAX=4: if_req and ls_req held high continuously → grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF. With CALCU16_MEMARB_RR_EN defined → LS,IF,LS,IF,...
- Reset mid-read, RD_LAT=4: assert rst_n=0 two cycles after ls_gnt for a load → no ls_rvalid ever appears for it; after release, a new if_req is served normally.
- Withdrawn request: ls_req pulses for one cycle while the arbiter is in WAIT → no ls_gnt, no mem access for it.
